alu_arbiter: RTL and testbench

//   Shares one registered alu (16-bit, 3-bit op, en-gated, 1-cycle latency) between two requesters.

---
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester and alu-side signal bundle for alu_arbiter.
// slave: arbiter side; master: requesters plus alu.
interface alu_arbiter_if #(
  parameter int N = 16
);
  logic         req0;
  logic         req1;
  logic [N-1:0] a0;
  logic [N-1:0] a1;
  logic [N-1:0] b0;
  logic [N-1:0] b1;
  logic [2:0]   op0;
  logic [2:0]   op1;
  logic         mov0;
  logic         mov1;
  logic         done0;
  logic         done1;
  logic [N-1:0] res;
  logic         o_f;
  logic         z_f;
  logic         n_f;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_op;
  logic         alu_mov_sel;
  logic         alu_en;
  logic [N-1:0] alu_sum;
  logic         alu_o;
  logic         alu_z;
  logic         alu_n;

  modport slave (
    input  req0, req1, a0, a1, b0, b1,
    input  op0, op1, mov0, mov1,
    output done0, done1, res, o_f, z_f, n_f,
    output alu_a, alu_b, alu_op,
    output alu_mov_sel, alu_en,
    input  alu_sum, alu_o, alu_z, alu_n
  );

  modport master (
    output req0, req1, a0, a1, b0, b1,
    output op0, op1, mov0, mov1,
    input  done0, done1, res, o_f, z_f, n_f,
    input  alu_a, alu_b, alu_op,
    input  alu_mov_sel, alu_en,
    output alu_sum, alu_o, alu_z, alu_n
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered alu between two requesters.
// Optional per-requester completion counters under ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int N = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]  gcnt0,
  output logic [7:0]  gcnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t       state;
  logic         last;
  logic         cur;
  logic         win;
  logic [N-1:0] a_w;
  logic [N-1:0] b_w;
  logic [2:0]   op_w;
  logic         mov_w;

  // A tie goes to the requester not granted last.
  always_comb begin
    win   = (bus.req0 & bus.req1) ? ~last : bus.req1;
    a_w   = win ? bus.a1 : bus.a0;
    b_w   = win ? bus.b1 : bus.b0;
    op_w  = win ? bus.op1 : bus.op0;
    mov_w = win ? bus.mov1 : bus.mov0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last            <= 1'b1;
      cur             <= 1'b0;
      bus.done0       <= 1'b0;
      bus.done1       <= 1'b0;
      bus.res         <= '0;
      bus.o_f         <= 1'b0;
      bus.z_f         <= 1'b0;
      bus.n_f         <= 1'b0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_op      <= '0;
      bus.alu_mov_sel <= 1'b0;
      bus.alu_en      <= 1'b0;
`ifdef ALU_ARB_STATS_EN
      gcnt0           <= '0;
      gcnt1           <= '0;
`endif
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            cur             <= win;
            last            <= win;
            bus.alu_a       <= a_w;
            bus.alu_b       <= b_w;
            bus.alu_op      <= op_w;
            bus.alu_mov_sel <= mov_w;
            bus.alu_en      <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          bus.alu_en <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          bus.res <= bus.alu_sum;
          bus.o_f <= bus.alu_o;
          bus.z_f <= bus.alu_z;
          bus.n_f <= bus.alu_n;
          if (cur) begin
            bus.done1 <= 1'b1;
`ifdef ALU_ARB_STATS_EN
            if (gcnt1 != 8'hFF)
              gcnt1 <= gcnt1 + 8'd1;
`endif
          end else begin
            bus.done0 <= 1'b1;
`ifdef ALU_ARB_STATS_EN
            if (gcnt0 != 8'hFF)
              gcnt0 <= gcnt0 + 8'd1;
`endif
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a registered xor alu stub.
// Define ALU_ARB_STATS_EN to also exercise the completion counters.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_arbiter_if #(.N(16)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [7:0] gcnt0;
  logic [7:0] gcnt1;
`endif

  alu_arbiter #(.N(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .gcnt0(gcnt0),
    .gcnt1(gcnt1)
`endif
  );

  always_ff @(posedge clk) begin
    if (bus.alu_en) begin
      bus.alu_sum <= bus.alu_a ^ bus.alu_b;
      bus.alu_z   <= ((bus.alu_a ^ bus.alu_b) == 16'h0);
      bus.alu_n   <= bus.alu_a[15] ^ bus.alu_b[15];
      bus.alu_o   <= 1'b0;
    end
  end

  typedef struct packed {
    logic        who;
    logic [15:0] res;
    logic        z;
    logic        n;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic who,
                              input logic [15:0] a,
                              input logic [15:0] b);
    exp_t e;
    e.who = who;
    e.res = a ^ b;
    e.z   = ((a ^ b) == 16'h0);
    e.n   = a[15] ^ b[15];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && (bus.done0 || bus.done1)) begin
      chk("done_both", {31'b0, bus.done0 & bus.done1}, 0);
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("who", {31'b0, bus.done1}, {31'b0, e.who});
        chk("res", {16'b0, bus.res}, {16'b0, e.res});
        chk("z_f", {31'b0, bus.z_f}, {31'b0, e.z});
        chk("n_f", {31'b0, bus.n_f}, {31'b0, e.n});
        chk("o_f", {31'b0, bus.o_f}, 0);
      end
    end
  end

  task automatic wait_done(input logic which, output int at);
    int n;
    n  = 0;
    at = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? bus.done1 : bus.done0) && n < 20);
    if (which ? bus.done1 : bus.done0)
      at = cyc;
    else
      chk("timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int t0;
  int t1;
  int prev;

  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    bus.op0 = 3'd2; bus.op1 = 3'd5;
    bus.mov0 = 0; bus.mov1 = 1;

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_res", {16'b0, bus.res}, 0);
    chk("rst_done", {30'b0, bus.done0, bus.done1}, 0);
    chk("rst_en", {31'b0, bus.alu_en}, 0);
    chk("rst_flags", {29'b0, bus.o_f, bus.z_f, bus.n_f}, 0);
    chk("rst_alu_a", {16'b0, bus.alu_a}, 0);

    // single request latency
    @(posedge clk); #1;
    bus.req0 = 1; bus.a0 = 16'hFF00; bus.b0 = 16'h0002;
    sb.push_back(mk(0, 16'hFF00, 16'h0002));
    @(posedge clk);
    @(negedge clk);
    chk("lat_en1", {31'b0, bus.alu_en}, 1);
    chk("lat_a", {16'b0, bus.alu_a}, 32'hFF00);
    chk("lat_op", {29'b0, bus.alu_op}, 2);
    @(negedge clk);
    chk("lat_en0", {31'b0, bus.alu_en}, 0);
    chk("lat_nodone", {31'b0, bus.done0}, 0);
    @(negedge clk);
    chk("lat_done0", {31'b0, bus.done0}, 1);
    chk("lat_done1", {31'b0, bus.done1}, 0);
    bus.req0 = 0;
    bus.a0 = 16'h1111;
    repeat (3) @(negedge clk);
    chk("idle_en", {31'b0, bus.alu_en}, 0);
    chk("hold_res", {16'b0, bus.res}, 32'hFF02);

    // tie after reset goes to requester 0
    do_reset();
    @(posedge clk); #1;
    bus.req0 = 1; bus.a0 = 16'h004E; bus.b0 = 16'h004E;
    bus.req1 = 1; bus.a1 = 16'h0007; bus.b1 = 16'h0000;
    sb.push_back(mk(0, 16'h004E, 16'h004E));
    sb.push_back(mk(1, 16'h0007, 16'h0000));
    wait_done(0, t0);
    bus.req0 = 0;
    wait_done(1, t1);
    bus.req1 = 0;
    chk("tie_gap", t1 - t0, 3);

    // both held: alternating grants
    @(posedge clk); #1;
    bus.req0 = 1; bus.a0 = 16'h8000; bus.b0 = 16'h0001;
    bus.req1 = 1; bus.a1 = 16'h1234; bus.b1 = 16'h1234;
    for (int i = 0; i < 4; i++)
      sb.push_back(i % 2 == 0 ? mk(0, 16'h8000, 16'h0001)
                              : mk(1, 16'h1234, 16'h1234));
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      wait_done(i[0], t0);
      if (i > 0) chk("rr_gap", t0 - prev, 3);
      prev = t0;
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (3) @(negedge clk);

    // reset during WAIT aborts
    @(posedge clk); #1;
    bus.req1 = 1; bus.a1 = 16'h00F0; bus.b1 = 16'h000F;
    @(posedge clk);
    @(negedge clk);
    chk("abort_en", {31'b0, bus.alu_en}, 1);
    @(negedge clk);
    rst = 1; bus.req1 = 0;
    @(negedge clk);
    chk("abort_done", {30'b0, bus.done0, bus.done1}, 0);
    chk("abort_res", {16'b0, bus.res}, 0);
    chk("abort_en0", {31'b0, bus.alu_en}, 0);
    @(posedge clk); #1;
    rst = 0;
    bus.req1 = 1; bus.a1 = 16'h0003; bus.b1 = 16'h0005;
    sb.push_back(mk(1, 16'h0003, 16'h0005));
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_en", {31'b0, bus.alu_en}, 1);
    chk("post_rst_a", {16'b0, bus.alu_a}, 3);
    chk("post_rst_mov", {31'b0, bus.alu_mov_sel}, 1);
    wait_done(1, t0);
    bus.req1 = 0;

`ifdef ALU_ARB_STATS_EN
    do_reset();
    @(negedge clk);
    chk("gcnt_clr", {16'b0, gcnt0, gcnt1}, 0);
    @(posedge clk); #1;
    bus.req0 = 1; bus.a0 = 16'h0F0F; bus.b0 = 16'h00FF;
    for (int i = 0; i < 300; i++)
      sb.push_back(mk(0, 16'h0F0F, 16'h00FF));
    for (int i = 0; i < 300; i++)
      wait_done(0, t0);
    bus.req0 = 0;
    repeat (2) @(negedge clk);
    chk("gcnt0_sat", {24'b0, gcnt0}, 255);
    chk("gcnt1_zero", {24'b0, gcnt1}, 0);
    do_reset();
    @(negedge clk);
    chk("gcnt_rst", {16'b0, gcnt0, gcnt1}, 0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
